interrupt_sequencer: RTL and testbench

//  CPU-side controller for the interrupt daisy chain (BOR/POR/PUC at the head, then peripherals).
//  - Decides when a chain request is accepted and returns INTACK to the chain head.
//  - Latches the vector index, then sequences interrupt entry: push PC, push SR, clear SR, fetch vector, load PC.
//  - Stalls the core while the sequence runs.

---
 rtl/interrupt_sequencer_pkg.sv | 31 +++
 rtl/interrupt_sequencer.sv | 104 ++++++++++
 tb/tb_interrupt_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the interrupt sequencer: IVT layout, vector indices, memory op codes, FSM states.
// No logic; constants only.
// Imported by the sequencer RTL and the bench.
package interrupt_sequencer_pkg;

   // IVT geometry and special indices
   localparam int          IDX_W_DEF     = 6;
   localparam logic [15:0] IVT_BASE_DEF  = 16'hFF80;
   localparam int          RESET_IDX_DEF = 63;
   localparam int          NMI_MIN_DEF   = 61;

   // Named vector indices (byte address = IVT_BASE + 2*idx)
   localparam int IVT_PORT1 = 50;   // 0xFFE4
   localparam int IVT_NMI   = 62;   // 0xFFFC
   localparam int IVT_RESET = 63;   // 0xFFFE

   // Memory operation encodings
   localparam logic [1:0] MEMOP_NONE    = 2'b00;
   localparam logic [1:0] MEMOP_PUSH_PC = 2'b01;
   localparam logic [1:0] MEMOP_PUSH_SR = 2'b10;
   localparam logic [1:0] MEMOP_READ_VEC = 2'b11;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ACK     = 3'd1;
   localparam logic [2:0] ST_PUSH_PC = 3'd2;
   localparam logic [2:0] ST_PUSH_SR = 3'd3;
   localparam logic [2:0] ST_FETCH   = 3'd4;
   localparam logic [2:0] ST_LOAD    = 3'd5;

endpackage

// File: rtl/interrupt_sequencer.sv
// Accepts a daisy-chain interrupt request, acks the chain head and runs entry: push PC, push SR, clear SR, fetch vector, load PC.
// Latency: INTACK 1 cycle after take; maskable entry ends with PCload 5 cycles after take, reset entry 3 cycles after take.
// Backpressure: each memory step holds until MemRdy; the core is stalled (IntBusy) for the whole sequence.
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
#(
   parameter int          IDX_W     = IDX_W_DEF,
   parameter logic [15:0] IVT_BASE  = IVT_BASE_DEF,
   parameter int          RESET_IDX = RESET_IDX_DEF,
   parameter int          NMI_MIN   = NMI_MIN_DEF
) (
   input  logic             MCLK,
   input  logic             RST,
   input  logic             INTREQ,
   input  logic [IDX_W-1:0] IntAddr,
   input  logic             GIE,
   input  logic             InstrDone,
   input  logic             MemRdy,
   output logic             INTACK,
   output logic             IntBusy,
   output logic             MemReq,
   output logic [1:0]       MemOp,
   output logic [15:0]      VecAddr,
   output logic             SRclr,
   output logic             PCload,
   output logic [IDX_W-1:0] IntIdx
);

   localparam logic [IDX_W-1:0] L_RESET_IDX = IDX_W'(RESET_IDX);
   localparam logic [IDX_W-1:0] L_NMI_MIN   = IDX_W'(NMI_MIN);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_req_reset;
   logic             w_take;
   logic             w_preempt;
   logic             w_mem_state;

   // A reset-index request bypasses GIE and instruction boundaries; NMIs bypass GIE only
   assign w_req_reset = INTREQ & (IntAddr == L_RESET_IDX);
   assign w_take      = w_req_reset | (INTREQ & InstrDone & (GIE | (IntAddr >= L_NMI_MIN)));
   // A reset request aborts any sequence in flight unless that sequence is already the reset entry
   assign w_preempt   = (r_state != ST_IDLE) & w_req_reset & (r_idx != L_RESET_IDX);

   // Next-state and latched-index selection
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (w_preempt) begin
         w_state_nxt = ST_ACK;
         w_idx_nxt   = L_RESET_IDX;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  w_state_nxt = ST_ACK;
                  w_idx_nxt   = IntAddr;
               end
            end
            ST_ACK:     w_state_nxt = (r_idx == L_RESET_IDX) ? ST_FETCH : ST_PUSH_PC;
            ST_PUSH_PC: if (MemRdy) w_state_nxt = ST_PUSH_SR;
            ST_PUSH_SR: if (MemRdy) w_state_nxt = ST_FETCH;
            ST_FETCH:   if (MemRdy) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and index registers with synchronous reset
   always_ff @(posedge MCLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Output decode from registered state; pulses are suppressed while RST is high and
   // the memory request is withdrawn in the preemption cycle so no partial push completes
   always_comb begin
      w_mem_state = (r_state == ST_PUSH_PC) | (r_state == ST_PUSH_SR) | (r_state == ST_FETCH);
      IntBusy     = (r_state != ST_IDLE);
      INTACK      = (r_state == ST_ACK) & ~RST;
      PCload      = (r_state == ST_LOAD) & ~RST;
      SRclr       = (r_state == ST_PUSH_SR) & MemRdy & ~w_preempt & ~RST;
      MemReq      = w_mem_state & ~w_preempt;
      case (r_state)
         ST_PUSH_PC: MemOp = MEMOP_PUSH_PC;
         ST_PUSH_SR: MemOp = MEMOP_PUSH_SR;
         ST_FETCH:   MemOp = MEMOP_READ_VEC;
         default:    MemOp = MEMOP_NONE;
      endcase
   end

   // IVT_BASE is aligned to the table size, so the entry address is a plain concatenation
   assign VecAddr = {IVT_BASE[15:IDX_W+1], r_idx, 1'b0};
   assign IntIdx  = r_idx;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
// Expected output vectors are hand-written constants.
module tb_interrupt_sequencer;
   import interrupt_sequencer_pkg::*;

   logic        MCLK = 1'b0;
   logic        RST = 1'b1;
   logic        INTREQ = 1'b0;
   logic [5:0]  IntAddr = '0;
   logic        GIE = 1'b0;
   logic        InstrDone = 1'b0;
   logic        MemRdy = 1'b0;
   logic        INTACK, IntBusy, MemReq, SRclr, PCload;
   logic [1:0]  MemOp;
   logic [15:0] VecAddr;
   logic [5:0]  IntIdx;

   int n_chk  = 0;
   int n_fail = 0;

   // {INTACK, IntBusy, MemReq, MemOp[1:0], SRclr, PCload}
   localparam logic [6:0] O_IDLE = 7'b0000000;
   localparam logic [6:0] O_ACK  = 7'b1100000;
   localparam logic [6:0] O_PC   = 7'b0110100;
   localparam logic [6:0] O_SRW  = 7'b0111000;
   localparam logic [6:0] O_SR   = 7'b0111010;
   localparam logic [6:0] O_FE   = 7'b0111100;
   localparam logic [6:0] O_LD   = 7'b0100001;
   localparam logic [6:0] O_PRE  = 7'b0101000;

   logic [6:0] w_outs;
   assign w_outs = {INTACK, IntBusy, MemReq, MemOp, SRclr, PCload};

   interrupt_sequencer dut (
      .MCLK(MCLK), .RST(RST), .INTREQ(INTREQ), .IntAddr(IntAddr), .GIE(GIE),
      .InstrDone(InstrDone), .MemRdy(MemRdy), .INTACK(INTACK), .IntBusy(IntBusy),
      .MemReq(MemReq), .MemOp(MemOp), .VecAddr(VecAddr), .SRclr(SRclr),
      .PCload(PCload), .IntIdx(IntIdx)
   );

   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge (input drive point)
   task automatic cyc();
      @(posedge MCLK);
      #1;
   endtask

   // Let combinational outputs settle, then compare the output vector
   task automatic chk_outs(input string tag, input logic [6:0] exp);
      #1;
      check(tag, {25'd0, w_outs}, {25'd0, exp});
   endtask

   task automatic idle_inputs();
      INTREQ = 1'b0; IntAddr = '0; GIE = 1'b0; InstrDone = 1'b0; MemRdy = 1'b1;
   endtask

   logic [6:0] seq_exp [0:5];

   initial begin
      seq_exp[0] = O_ACK; seq_exp[1] = O_PC; seq_exp[2] = O_SR;
      seq_exp[3] = O_FE;  seq_exp[4] = O_LD; seq_exp[5] = O_IDLE;

      // 1. reset state, then reset vector entry without InstrDone
      idle_inputs();
      RST = 1'b1;
      cyc(); cyc();
      chk_outs("rst_outs", O_IDLE);
      check("rst_idx", {26'd0, IntIdx}, 32'd0);
      check("rst_vec", {16'd0, VecAddr}, 32'h0000FF80);
      RST = 1'b0; INTREQ = 1'b1; IntAddr = 6'd63;
      chk_outs("r_take", O_IDLE);
      cyc(); INTREQ = 1'b0;
      chk_outs("r_ack", O_ACK);
      check("r_idx", {26'd0, IntIdx}, 32'd63);
      cyc(); chk_outs("r_fetch", O_FE);
      check("r_vec", {16'd0, VecAddr}, 32'h0000FFFE);
      cyc(); chk_outs("r_load", O_LD);
      cyc(); chk_outs("r_idle", O_IDLE);

      // 2. maskable PORT1 entry, INTREQ dropped right after take
      cyc(); GIE = 1'b1; InstrDone = 1'b1; INTREQ = 1'b1; IntAddr = 6'(IVT_PORT1);
      chk_outs("p1_take", O_IDLE);
      for (int i = 0; i < 6; i++) begin
         cyc(); INTREQ = 1'b0; IntAddr = 6'd5;
         chk_outs($sformatf("p1_seq%0d", i), seq_exp[i]);
         if (i == 3) check("p1_vec", {16'd0, VecAddr}, 32'h0000FFE4);
      end
      check("p1_idx", {26'd0, IntIdx}, 32'd50);

      // 3. masked by GIE, not at an instruction boundary, then NMI index ignores GIE
      GIE = 1'b0; InstrDone = 1'b1; INTREQ = 1'b1; IntAddr = 6'(IVT_PORT1);
      for (int i = 0; i < 3; i++) begin
         cyc(); chk_outs($sformatf("mask%0d", i), O_IDLE);
      end
      GIE = 1'b1; InstrDone = 1'b0;
      cyc(); chk_outs("no_boundary", O_IDLE);
      GIE = 1'b0; InstrDone = 1'b1; IntAddr = 6'(IVT_NMI);
      for (int i = 0; i < 6; i++) begin
         cyc(); INTREQ = 1'b0;
         chk_outs($sformatf("nmi_seq%0d", i), seq_exp[i]);
      end
      check("nmi_idx", {26'd0, IntIdx}, 32'd62);

      // 4. three wait cycles in each memory state
      GIE = 1'b1; InstrDone = 1'b1; INTREQ = 1'b1; IntAddr = 6'(IVT_PORT1); MemRdy = 1'b0;
      cyc(); INTREQ = 1'b0; chk_outs("w_ack", O_ACK);
      for (int s = 0; s < 3; s++) begin
         for (int w = 0; w < 4; w++) begin
            cyc(); MemRdy = (w == 3);
            chk_outs($sformatf("w_s%0d_c%0d", s, w),
                     (s == 0) ? O_PC : (s == 1) ? ((w == 3) ? O_SR : O_SRW) : O_FE);
            if (s == 2) check($sformatf("w_vec%0d", w), {16'd0, VecAddr}, 32'h0000FFE4);
         end
      end
      cyc(); chk_outs("w_load", O_LD);
      cyc(); chk_outs("w_idle", O_IDLE);

      // 5. reset request preempts during PUSH_SR
      MemRdy = 1'b1; INTREQ = 1'b1; IntAddr = 6'(IVT_PORT1);
      cyc(); INTREQ = 1'b0; chk_outs("pre_ack1", O_ACK);
      cyc(); chk_outs("pre_pc", O_PC);
      cyc(); INTREQ = 1'b1; IntAddr = 6'd63;
      chk_outs("pre_sr", O_PRE);
      cyc(); INTREQ = 1'b0; chk_outs("pre_ack2", O_ACK);
      check("pre_idx", {26'd0, IntIdx}, 32'd63);
      cyc(); chk_outs("pre_fetch", O_FE);
      check("pre_vec", {16'd0, VecAddr}, 32'h0000FFFE);
      cyc(); chk_outs("pre_load", O_LD);
      cyc(); chk_outs("pre_idle", O_IDLE);

      // 6. RST pulsed during FETCH aborts without pulses
      INTREQ = 1'b1; IntAddr = 6'(IVT_PORT1);
      cyc(); INTREQ = 1'b0; chk_outs("rf_ack", O_ACK);
      cyc(); chk_outs("rf_pc", O_PC);
      cyc(); chk_outs("rf_sr", O_SR);
      cyc(); chk_outs("rf_fetch", O_FE);
      RST = 1'b1;
      cyc(); RST = 1'b0;
      chk_outs("rf_after", O_IDLE);
      check("rf_idx", {26'd0, IntIdx}, 32'd0);
      check("rf_vec", {16'd0, VecAddr}, 32'h0000FF80);
      cyc(); chk_outs("rf_stay", O_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
